// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the posted-write store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } sb_state_e;

  // One buffered store. Field widths follow the package defaults; the
  // top-level ADDR_W/DATA_W parameters are expected to match them.
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  // Pointer width for a power-of-two depth (at least one bit).
  function automatic int sb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and memory-side signals of the store buffer.
// slave  : the store buffer itself.
// master : the environment (pipeline register + data memory).
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
);

  // Pipeline request / response
  logic              MemWrite_i;
  logic              MemRead_i;
  logic [ADDR_W-1:0] Address_i;
  logic [DATA_W-1:0] Writedata_i;
  logic              flush_i;
  logic [DATA_W-1:0] Readdata_o;
  logic              stall_o;
  logic              flush_done_o;

  // Data memory port
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_write_o;
  logic              mem_read_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  modport slave (
    input  MemWrite_i, MemRead_i, Address_i, Writedata_i, flush_i,
    input  mem_rdata_i, mem_ready_i,
    output Readdata_o, stall_o, flush_done_o,
    output mem_addr_o, mem_wdata_o, mem_write_o, mem_read_o
  );

  modport master (
    output MemWrite_i, MemRead_i, Address_i, Writedata_i, flush_i,
    output mem_rdata_i, mem_ready_i,
    input  Readdata_o, stall_o, flush_done_o,
    input  mem_addr_o, mem_wdata_o, mem_write_o, mem_read_o
  );

endinterface

// File: rtl/store_buffer_cam.sv
// Address match across all buffered stores. Returns the youngest valid
// entry whose address equals i_addr; age is measured backwards from tail.
module store_buffer_cam
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  i_entry_addr,
  input  logic [DEPTH-1:0]              i_valid,
  input  logic [sb_ptr_w(DEPTH)-1:0]    i_tail,
  output logic                          o_hit,
  output logic [sb_ptr_w(DEPTH)-1:0]    o_hit_idx
);

  localparam int PTR_W = sb_ptr_w(DEPTH);

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); later hits override.
  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    o_hit     = 1'b0;
    o_hit_idx = '0;
    idx       = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = i_tail - PTR_W'(k);
      if (i_valid[idx] && (i_entry_addr[idx] == i_addr)) begin
        o_hit     = 1'b1;
        o_hit_idx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and the data memory.
// Stores are absorbed in one cycle and drained whenever the memory port is
// free; loads forward from the youngest matching buffered store or miss to
// memory. Load misses own the port over drains.
// Optional feature: define STORE_BUFFER_COALESCE_EN to merge a store into an
// already-buffered entry with the same address instead of allocating.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input logic           clk_i,
  input logic           rst_i,
  store_buffer_if.slave sb
);

  localparam int PTR_W = sb_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // State
  sb_state_e        r_state;
  sb_state_e        w_state_next;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  sb_entry_t        r_entries [DEPTH];

  // Lookup
  logic [DEPTH-1:0][ADDR_W-1:0] w_entry_addr;
  logic [DEPTH-1:0]             w_valid;
  logic                         w_hit;
  logic [PTR_W-1:0]             w_hit_idx;
  sb_entry_t                    w_head;

  // Control
  logic w_store;
  logic w_load;
  logic w_full;
  logic w_empty;
  logic w_flushing;
  logic w_miss;
  logic w_drain;
  logic w_pop;
  logic w_push;
  logic w_coalesce;
  logic w_stall;
  logic w_flush_done;

  // Output values before reset gating
  logic [DATA_W-1:0] w_readdata;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_store    = sb.MemWrite_i;
  assign w_load     = sb.MemRead_i;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_entries[r_head];

  // A flush pulse blocks requests already in the cycle it arrives.
  assign w_flushing = (r_state == FLUSH) || sb.flush_i;

  // Address list and occupancy mask for the CAM: slot i is live when its
  // distance from head is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_addr[i] = r_entries[i].addr;
      offset          = PTR_W'(i) - r_head;
      w_valid[i]      = ({1'b0, offset} < r_count);
    end
  end

  store_buffer_cam #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_cam (
    .i_addr       (sb.Address_i),
    .i_entry_addr (w_entry_addr),
    .i_valid      (w_valid),
    .i_tail       (r_tail),
    .o_hit        (w_hit),
    .o_hit_idx    (w_hit_idx)
  );

  // Port arbitration: a load miss takes the port; otherwise drain the head.
  assign w_miss  = w_load && !w_hit && !w_flushing;
  assign w_drain = !w_empty && !w_miss;
  assign w_pop   = w_drain && sb.mem_ready_i;

`ifdef STORE_BUFFER_COALESCE_EN
  // Merge into the matching entry unless that entry is the head leaving now.
  assign w_coalesce = w_store && !w_flushing && w_hit &&
                      !(w_pop && (w_hit_idx == r_head));
`else
  assign w_coalesce = 1'b0;
`endif

  // A full buffer still accepts a store when the head pops in the same cycle.
  assign w_push = w_store && !w_flushing && !w_coalesce && (!w_full || w_pop);

  assign w_stall = (w_flushing && (w_store || w_load))
                || (w_store && !w_flushing && !w_coalesce && w_full && !w_pop)
                || (w_miss && !sb.mem_ready_i);

  // Flush completes once the buffer is empty, counting the emptying pop.
  assign w_flush_done = (r_state == FLUSH) &&
                        (w_empty || ((r_count == CNT_W'(1)) && w_pop));

  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Load result: forwarded data on a hit, memory data on a miss.
  always_comb begin
    w_readdata = '0;
    if (w_load && !w_flushing) begin
      w_readdata = w_hit ? r_entries[w_hit_idx].data : sb.mem_rdata_i;
    end
  end

  // Memory address/data mux for the owner of the port this cycle.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_miss) begin
      w_mem_addr = sb.Address_i;
    end else if (w_drain) begin
      w_mem_addr  = w_head.addr;
      w_mem_wdata = w_head.data;
    end
  end

  // Next-state logic of the drain/flush controller.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (sb.flush_i)    w_state_next = FLUSH;
        else if (w_push)   w_state_next = DRAIN;
      end
      DRAIN: begin
        if (sb.flush_i)              w_state_next = FLUSH;
        else if (w_count_next == '0) w_state_next = IDLE;
      end
      FLUSH: begin
        if (w_flush_done)  w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register, FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
    end
  end

  // Entry storage: allocate at tail, or merge data in place.
  // NOTE: the entry array has no reset; count=0 already marks every slot
  // invalid, so clearing the contents would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_entries[r_tail] <= '{addr: sb.Address_i, data: sb.Writedata_i};
    end else if (w_coalesce) begin
      r_entries[w_hit_idx].data <= sb.Writedata_i;
    end
  end

  // All outputs are held at zero while reset is asserted.
  assign sb.Readdata_o   = rst_i ? w_readdata   : '0;
  assign sb.stall_o      = rst_i ? w_stall      : 1'b0;
  assign sb.flush_done_o = rst_i ? w_flush_done : 1'b0;
  assign sb.mem_addr_o   = rst_i ? w_mem_addr   : '0;
  assign sb.mem_wdata_o  = rst_i ? w_mem_wdata  : '0;
  assign sb.mem_write_o  = rst_i ? w_drain      : 1'b0;
  assign sb.mem_read_o   = rst_i ? w_miss       : 1'b0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [31:0] RDATA = 32'hCAFE_F00D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .sb    (sb_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_flush = 1'b0;

  // Expectations computed mid-cycle, applied at the next rising edge.
  bit e_valid, e_pop, e_push, e_coal, e_done, e_flush_in;
  int e_j;
  logic [31:0] e_addr_in, e_data_in;

  always @(negedge clk) begin
    bit          flushing, hit, rd, wr, stall, miss;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    int          n, j;
    e_valid = 1'b0;
    if (!rst_n) begin
      check("rst_stall",    sb_if.stall_o,      0);
      check("rst_done",     sb_if.flush_done_o, 0);
      check("rst_mem_wr",   sb_if.mem_write_o,  0);
      check("rst_mem_rd",   sb_if.mem_read_o,   0);
      check("rst_mem_addr", sb_if.mem_addr_o,   0);
      check("rst_rdata",    sb_if.Readdata_o,   0);
    end else begin
      n = q.size();
      j = -1;
      for (int i = 0; i < n; i++) if (q[i].addr == sb_if.Address_i) j = i;
      hit = (j >= 0);
      flushing = m_flush || sb_if.flush_i;
      rd = 0; wr = 0; stall = 0; miss = 0;
      e_pop = 0; e_push = 0; e_coal = 0; e_done = 0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      if (flushing) begin
        wr     = (n > 0);
        stall  = sb_if.MemWrite_i || sb_if.MemRead_i;
        e_done = m_flush && (n == 0 || (n == 1 && sb_if.mem_ready_i));
      end else begin
        miss = sb_if.MemRead_i && !hit;
        rd   = miss;
        wr   = (n > 0) && !miss;
        if (sb_if.MemRead_i) exp_rdata = hit ? q[j].data : sb_if.mem_rdata_i;
        if (miss && !sb_if.mem_ready_i) stall = 1;
      end
      e_pop = wr && sb_if.mem_ready_i;
      if (sb_if.MemWrite_i && !flushing) begin
`ifdef STORE_BUFFER_COALESCE_EN
        if (hit && !(j == 0 && e_pop)) e_coal = 1;
`endif
        if (!e_coal) begin
          if (n < DEPTH || e_pop) e_push = 1;
          else stall = 1;
        end
      end
      if (rd) exp_addr = sb_if.Address_i;
      else if (wr) begin exp_addr = q[0].addr; exp_wdata = q[0].data; end

      check("stall",      sb_if.stall_o,      stall);
      check("mem_write",  sb_if.mem_write_o,  wr);
      check("mem_read",   sb_if.mem_read_o,   rd);
      check("flush_done", sb_if.flush_done_o, e_done);
      if (rd || wr) check("mem_addr", sb_if.mem_addr_o, exp_addr);
      if (wr) check("mem_wdata", sb_if.mem_wdata_o, exp_wdata);
      if (!sb_if.MemRead_i || (!flushing && !stall))
        check("readdata", sb_if.Readdata_o, exp_rdata);

      e_valid    = 1'b1;
      e_j        = j;
      e_flush_in = sb_if.flush_i;
      e_addr_in  = sb_if.Address_i;
      e_data_in  = sb_if.Writedata_i;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_flush = 1'b0;
    end else if (e_valid) begin
      if (e_coal) q[e_j].data = e_data_in;
      if (e_pop) void'(q.pop_front());
      if (e_push) q.push_back('{addr: e_addr_in, data: e_data_in});
      if (m_flush && e_done) m_flush = 1'b0;
      else if (!m_flush && e_flush_in) m_flush = 1'b1;
      e_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step_in(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input bit f, input bit rdy);
    sb_if.MemWrite_i  = w;
    sb_if.MemRead_i   = r;
    sb_if.Address_i   = a;
    sb_if.Writedata_i = d;
    sb_if.flush_i     = f;
    sb_if.mem_ready_i = rdy;
    @(negedge clk);
  endtask

  task automatic step_out();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step_in(0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    sb_if.mem_rdata_i = RDATA;
    // Reset with a load and ready presented: outputs must still be zero.
    step_in(0, 1, 32'h10, 0, 0, 1);
    check("L_rst_mem_read", sb_if.mem_read_o, 0);
    check("L_rst_readdata", sb_if.Readdata_o, 0);
    step_out();
    rst_n = 1'b1;

    // Forward from a single buffered store.
    step_in(1, 0, 32'h10, 32'hAAAA5555, 0, 0);
    check("L_t1_store_stall", sb_if.stall_o, 0);
    step_out();
    step_in(0, 1, 32'h10, 0, 0, 0);
    check("L_t1_fwd_data",  sb_if.Readdata_o, 32'hAAAA5555);
    check("L_t1_no_memrd",  sb_if.mem_read_o, 0);
    check("L_t1_no_stall",  sb_if.stall_o, 0);
    step_out();
    idle(1);
    check("L_t1_drain_addr", sb_if.mem_addr_o, 32'h10);
    step_out();

    // Two stores to one address: youngest forwards, both drain in order.
    step_in(1, 0, 32'h4, 32'd1, 0, 0); step_out();
    step_in(1, 0, 32'h4, 32'd2, 0, 0); step_out();
    step_in(0, 1, 32'h4, 0, 0, 0);
    check("L_t2_youngest", sb_if.Readdata_o, 32'd2);
    step_out();
`ifndef STORE_BUFFER_COALESCE_EN
    idle(1); check("L_t2_first_write",  sb_if.mem_wdata_o, 32'd1); step_out();
`endif
    idle(1); check("L_t2_second_write", sb_if.mem_wdata_o, 32'd2); step_out();
    idle(1); check("L_t2_empty",        sb_if.mem_write_o, 0);     step_out();

    // Fill to DEPTH, fifth store stalls, accepted when head pops.
    for (int i = 0; i < DEPTH; i++) begin
      step_in(1, 0, 32'h100 + i, i + 1, 0, 0);
      check("L_t3_fill_stall", sb_if.stall_o, 0);
      step_out();
    end
    step_in(1, 0, 32'h104, 32'd5, 0, 0);
    check("L_t3_full_stall", sb_if.stall_o, 1);
    step_out();
    step_in(1, 0, 32'h104, 32'd5, 0, 1);
    check("L_t3_accept_on_pop", sb_if.stall_o, 0);
    check("L_t3_pop_addr",      sb_if.mem_addr_o, 32'h100);
    step_out();
    step_in(1, 0, 32'h200, 32'd6, 0, 0);
    check("L_t3_still_full", sb_if.stall_o, 1);
    step_out();
    for (int i = 0; i < DEPTH; i++) begin
      idle(1);
      check("L_t3_drain_order", sb_if.mem_wdata_o, i + 2);
      step_out();
    end
    idle(1); check("L_t3_drained", sb_if.mem_write_o, 0); step_out();

    // Load miss owns the port; drain resumes afterwards.
    step_in(1, 0, 32'h8, 32'h88, 0, 0); step_out();
    step_in(0, 1, 32'hC, 0, 0, 1);
    check("L_t4_miss_read",  sb_if.mem_read_o, 1);
    check("L_t4_miss_data",  sb_if.Readdata_o, RDATA);
    check("L_t4_no_write",   sb_if.mem_write_o, 0);
    check("L_t4_miss_addr",  sb_if.mem_addr_o, 32'hC);
    check("L_t4_miss_stall", sb_if.stall_o, 0);
    step_out();
    step_in(0, 1, 32'hC, 0, 0, 0);
    check("L_t4_miss_wait_stall", sb_if.stall_o, 1);
    step_out();
    idle(1);
    check("L_t4_resume_addr", sb_if.mem_addr_o, 32'h8);
    check("L_t4_resume_data", sb_if.mem_wdata_o, 32'h88);
    step_out();

    // Youngest match across wrapped pointers.
    step_in(1, 0, 32'h30, 32'd1, 0, 0); step_out();
    step_in(1, 0, 32'h34, 32'd2, 0, 0); step_out();
    step_in(1, 0, 32'h30, 32'd3, 0, 0); step_out();
    step_in(0, 1, 32'h30, 0, 0, 0); check("L_t8_fwd_30", sb_if.Readdata_o, 32'd3); step_out();
    step_in(0, 1, 32'h34, 0, 0, 0); check("L_t8_fwd_34", sb_if.Readdata_o, 32'd2); step_out();
    repeat (3) begin idle(1); step_out(); end

    // Flush of three entries with a load held against it.
    step_in(1, 0, 32'h20, 32'h20, 0, 0); step_out();
    step_in(1, 0, 32'h24, 32'h24, 0, 0); step_out();
    step_in(1, 0, 32'h28, 32'h28, 0, 0); step_out();
    step_in(0, 1, 32'h20, 0, 1, 1);
    check("L_t5_c0_stall", sb_if.stall_o, 1);
    check("L_t5_c0_addr",  sb_if.mem_addr_o, 32'h20);
    check("L_t5_c0_done",  sb_if.flush_done_o, 0);
    step_out();
    step_in(0, 1, 32'h20, 0, 0, 1);
    check("L_t5_c1_stall", sb_if.stall_o, 1);
    check("L_t5_c1_addr",  sb_if.mem_addr_o, 32'h24);
    step_out();
    step_in(0, 1, 32'h20, 0, 0, 1);
    check("L_t5_c2_stall", sb_if.stall_o, 1);
    check("L_t5_c2_addr",  sb_if.mem_addr_o, 32'h28);
    check("L_t5_c2_done",  sb_if.flush_done_o, 1);
    step_out();
    step_in(0, 1, 32'h20, 0, 0, 1);
    check("L_t5_after_stall", sb_if.stall_o, 0);
    check("L_t5_after_done",  sb_if.flush_done_o, 0);
    step_out();

    // Flush while empty: done the following cycle.
    step_in(0, 0, 0, 0, 1, 1); check("L_t6_c0_done", sb_if.flush_done_o, 0); step_out();
    idle(1);                   check("L_t6_c1_done", sb_if.flush_done_o, 1); step_out();
    idle(1);                   check("L_t6_c2_done", sb_if.flush_done_o, 0); step_out();

    // Flush request during an active flush is ignored.
    step_in(1, 0, 32'h50, 32'h50, 0, 0); step_out();
    step_in(1, 0, 32'h54, 32'h54, 0, 0); step_out();
    step_in(0, 0, 0, 0, 1, 0); step_out();
    step_in(0, 0, 0, 0, 1, 0); check("L_t7_wait_done", sb_if.flush_done_o, 0); step_out();
    idle(1); step_out();
    step_in(0, 0, 0, 0, 1, 1); check("L_t7_done", sb_if.flush_done_o, 1); step_out();
    idle(1); check("L_t7_no_second_done", sb_if.flush_done_o, 0); step_out();

    // Asynchronous reset while two entries wait to drain.
    step_in(1, 0, 32'h40, 32'h40, 0, 0); step_out();
    step_in(1, 0, 32'h44, 32'h44, 0, 0); step_out();
    sb_if.MemWrite_i  = 0;
    sb_if.mem_ready_i = 0;
    #1;
    check("L_t9_pre_rst_write", sb_if.mem_write_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("L_t9_rst_write", sb_if.mem_write_o, 0);
    check("L_t9_rst_addr",  sb_if.mem_addr_o, 0);
    step_out();
    rst_n = 1'b1;
    step_in(0, 1, 32'h40, 0, 0, 1);
    check("L_t9_post_miss", sb_if.mem_read_o, 1);
    check("L_t9_post_addr", sb_if.mem_addr_o, 32'h40);
    check("L_t9_post_data", sb_if.Readdata_o, RDATA);
    check("L_t9_post_nowr", sb_if.mem_write_o, 0);
    step_out();
    idle(1); step_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
